// File: rtl/obuf_writeback_packer_if.sv
// ============================================================================
// Module  : obuf_writeback_packer_if
// Purpose : OBUF beat input stream and DDR word output stream of the packer.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface obuf_writeback_packer_if #(
    parameter int DDR_BANDWIDTH = 512,
    parameter int NUM_BANKS     = 8,
    parameter int DATA_WIDTH    = 8
);
    localparam int BEAT_W = NUM_BANKS * DATA_WIDTH;
    localparam int RATIO  = (BEAT_W > 0) ? (DDR_BANDWIDTH / BEAT_W) : 1;

    logic                     in_valid;
    logic                     in_ready;
    logic [BEAT_W-1:0]        in_data;
    logic                     in_last;
    logic                     out_valid;
    logic                     out_ready;
    logic [DDR_BANDWIDTH-1:0] out_data;
    logic [RATIO-1:0]         out_keep;
    logic                     out_last;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_keep, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_keep, out_last
    );
endinterface

`default_nettype wire

// File: rtl/obuf_writeback_packer.sv
// ============================================================================
// Module  : obuf_writeback_packer
// Purpose : Packs RATIO bank-interleaved OBUF beats into one DDR word, with
//           partial-word flush on in_last. Optional counters: OBUF_WB_PACK_STATS_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module obuf_writeback_packer #(
    parameter int DDR_BANDWIDTH = 512,
    parameter int NUM_BANKS     = 8,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    obuf_writeback_packer_if.slave       bus
`ifdef OBUF_WB_PACK_STATS_EN
    ,
    input  logic                         stats_clr,
    output logic [31:0]                  word_count,
    output logic [31:0]                  stall_count
`endif
);

    localparam int BEAT_W    = NUM_BANKS * DATA_WIDTH;
    localparam int RATIO     = DDR_BANDWIDTH / BEAT_W;
    localparam int CNT_W     = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int ACC_SLOTS = (RATIO > 1) ? (RATIO - 1) : 1;

    if ((RATIO < 1) || (RATIO * BEAT_W != DDR_BANDWIDTH)) begin : g_ratio_check
        $error("obuf_writeback_packer: DDR_BANDWIDTH must be an exact multiple >=1 of NUM_BANKS*DATA_WIDTH");
    end

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t                          state_q;
    logic [CNT_W-1:0]                beat_cnt_q;
    logic [ACC_SLOTS-1:0][BEAT_W-1:0] acc_q;
    logic                            pend_last_q;
    logic                            out_valid_q;
    logic [DDR_BANDWIDTH-1:0]        out_data_q;
    logic [RATIO-1:0]                out_keep_q;
    logic                            out_last_q;

    logic                            out_free;
    logic                            cnt_full;
    logic                            in_ready;
    logic                            accept;
    logic                            completing;
    logic [CNT_W-1:0]                beat_cnt_inc_d;
    logic [DDR_BANDWIDTH-1:0]        fill_word_d;
    logic [DDR_BANDWIDTH-1:0]        wait_word_d;
    logic [RATIO-1:0]                keep_d;

    assign out_free       = !out_valid_q || bus.out_ready;
    assign cnt_full       = (beat_cnt_q == CNT_W'(RATIO - 1));
    assign in_ready       = (state_q == ST_FILL) && (!cnt_full || out_free);
    assign accept         = bus.in_valid && in_ready;
    assign completing     = cnt_full || bus.in_last;
    assign beat_cnt_inc_d = beat_cnt_q + CNT_W'(1);

    // Slot s of the outgoing word: accumulated beat below beat_cnt, the live
    // beat at beat_cnt (fill path only), zero above.
    for (genvar s = 0; s < RATIO; s++) begin : g_slot
        localparam logic [CNT_W-1:0] SLOT = CNT_W'(s);

        assign keep_d[s] = (SLOT <= beat_cnt_q);

        if (s < RATIO - 1) begin : g_acc_slot
            assign fill_word_d[s*BEAT_W +: BEAT_W] =
                (SLOT <  beat_cnt_q) ? acc_q[s]    :
                (SLOT == beat_cnt_q) ? bus.in_data : '0;
            assign wait_word_d[s*BEAT_W +: BEAT_W] =
                (SLOT <= beat_cnt_q) ? acc_q[s] : '0;
        end else begin : g_top_slot
            assign fill_word_d[s*BEAT_W +: BEAT_W] =
                (SLOT == beat_cnt_q) ? bus.in_data : '0;
            assign wait_word_d[s*BEAT_W +: BEAT_W] = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_FILL;
            beat_cnt_q  <= '0;
            acc_q       <= '0;
            pend_last_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end

            case (state_q)
                ST_FILL: begin
                    if (accept) begin
                        if (!completing) begin
                            for (int s = 0; s < ACC_SLOTS; s++) begin
                                if (CNT_W'(s) == beat_cnt_q) begin
                                    acc_q[s] <= bus.in_data;
                                end
                            end
                            beat_cnt_q <= beat_cnt_inc_d;
                        end else if (out_free) begin
                            out_data_q  <= fill_word_d;
                            out_keep_q  <= keep_d;
                            out_last_q  <= bus.in_last;
                            out_valid_q <= 1'b1;
                            beat_cnt_q  <= '0;
                            acc_q       <= '0;
                        end else begin
                            // Early last beat with the output still occupied:
                            // park it in the accumulator until the slot frees.
                            for (int s = 0; s < ACC_SLOTS; s++) begin
                                if (CNT_W'(s) == beat_cnt_q) begin
                                    acc_q[s] <= bus.in_data;
                                end
                            end
                            pend_last_q <= 1'b1;
                            state_q     <= ST_WAIT;
                        end
                    end
                end

                ST_WAIT: begin
                    if (out_free) begin
                        out_data_q  <= wait_word_d;
                        out_keep_q  <= keep_d;
                        out_last_q  <= pend_last_q;
                        out_valid_q <= 1'b1;
                        beat_cnt_q  <= '0;
                        acc_q       <= '0;
                        pend_last_q <= 1'b0;
                        state_q     <= ST_FILL;
                    end
                end

                default: begin
                    state_q <= ST_FILL;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_keep  = out_keep_q;
    assign bus.out_last  = out_last_q;

`ifdef OBUF_WB_PACK_STATS_EN
    logic [31:0] word_count_q;
    logic [31:0] stall_count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_count_q  <= '0;
            stall_count_q <= '0;
        end else if (stats_clr) begin
            word_count_q  <= '0;
            stall_count_q <= '0;
        end else begin
            if (out_valid_q && bus.out_ready) begin
                word_count_q <= word_count_q + 32'd1;
            end
            if (bus.in_valid && !in_ready) begin
                stall_count_q <= stall_count_q + 32'd1;
            end
        end
    end

    assign word_count  = word_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule

`default_nettype wire
